// File: rtl/color_frame_sequencer_pkg.sv
// Shared constants, state encoding and channel-to-register mapping for the
// RGBC colour sensor frame sequencer.
package color_frame_sequencer_pkg;

  // 7-bit address 0x29 expressed as write / read address bytes
  localparam logic [7:0] SENSOR_ADDR_WR = 8'h52;
  localparam logic [7:0] SENSOR_ADDR_RD = 8'h53;

  // Sensor register map
  localparam logic [7:0] REG_ENABLE = 8'h00;
  localparam logic [7:0] REG_ATIME  = 8'h01;
  localparam logic [7:0] REG_CDATA  = 8'h14;
  localparam logic [7:0] REG_RDATA  = 8'h16;
  localparam logic [7:0] REG_GDATA  = 8'h18;
  localparam logic [7:0] REG_BDATA  = 8'h1A;

  // Init write payloads: PON|AEN, then integration time
  localparam logic [7:0] ENABLE_PON_AEN = 8'h03;
  localparam logic [7:0] ATIME_VALUE    = 8'hF6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_COLLECT    = 3'd2,
    ST_NEXT       = 3'd3,
    ST_PUBLISH    = 3'd4,
    ST_FAIL       = 3'd5,
    ST_INIT_EN_WR = 3'd6,
    ST_INIT_AT_WR = 3'd7
  } state_t;

  // Channel order within a frame: CLEAR, RED, GREEN, BLUE
  function automatic logic [7:0] chan_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    chan_reg = REG_CDATA;
      2'd1:    chan_reg = REG_RDATA;
      2'd2:    chan_reg = REG_GDATA;
      default: chan_reg = REG_BDATA;
    endcase
  endfunction

endpackage

// File: rtl/color_seq_timer.sv
// Frame period tick generator plus per-transaction timeout counter.
module color_seq_timer #(
  parameter int PERIOD_CYCLES  = 2500000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_tmo_clr,
  input  logic i_tmo_en,
  output logic o_tick,
  output logic o_timeout
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT_CYCLES);

  logic [PW-1:0] r_period_cnt;
  logic [TW-1:0] r_tmo_cnt;

  // Free-running period counter, held at zero while periodic mode is off
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                        r_period_cnt <= '0;
    else if (!i_run)                     r_period_cnt <= '0;
    else if (r_period_cnt == PERIOD_LAST) r_period_cnt <= '0;
    else                                 r_period_cnt <= r_period_cnt + 1'b1;
  end

  assign o_tick = i_run && (r_period_cnt == PERIOD_LAST);

  // Transaction age counter; parks at the limit so the timeout stays asserted
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_tmo_cnt <= '0;
    else if (i_tmo_clr)                        r_tmo_cnt <= '0;
    else if (i_tmo_en && r_tmo_cnt != TMO_LIMIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign o_timeout = (r_tmo_cnt == TMO_LIMIT);

endmodule

// File: rtl/color_frame_sequencer.sv
// RGBC frame sequencer: issues four 2-byte register reads per frame to the
// I2C byte master and publishes the assembled channel words atomically.
// Optional sensor init writes are built when COLOR_SEQ_INIT_EN is defined.
module color_frame_sequencer
  import color_frame_sequencer_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 2500000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_wdata,
  output logic [1:0]  cmd_len,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  input  logic        txn_done,
  input  logic        txn_nack,
  output logic [15:0] clear_val,
  output logic [15:0] red_val,
  output logic [15:0] green_val,
  output logic [15:0] blue_val,
  output logic        frame_valid,
  output logic        busy,
  output logic        err,
  output logic [7:0]  overrun_cnt
);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [15:0] r_shadow [3];
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_reg;
  logic [1:0]  r_cmd_len;
  logic [15:0] r_clear, r_red, r_green, r_blue;
  logic        r_frame_valid;
  logic        r_busy;
  logic        r_err;
  logic [7:0]  r_overrun;
  logic        r_tmo_clr;
`ifdef COLOR_SEQ_INIT_EN
  logic        r_cmd_rw;
  logic [7:0]  r_cmd_wdata;
  logic        r_init_done;
  logic        r_init_failed;
`endif

  logic       w_tick;
  logic       w_timeout_raw;
  logic       w_timeout;
  logic       w_trig;
  logic       w_active;
  logic [1:0] w_byte_cnt_next;
  logic [7:0] w_lo_next;
  logic [7:0] w_hi_next;

  color_seq_timer #(
    .PERIOD_CYCLES  (PERIOD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_run     (run),
    .i_tmo_clr (r_tmo_clr),
    .i_tmo_en  (w_active),
    .o_tick    (w_tick),
    .o_timeout (w_timeout_raw)
  );

  assign w_trig   = w_tick | start;
  assign w_active = (r_state == ST_ISSUE) || (r_state == ST_COLLECT) ||
                    (r_state == ST_INIT_EN_WR) || (r_state == ST_INIT_AT_WR);
  // The counter still holds the previous transaction's age during the clear cycle
  assign w_timeout = w_timeout_raw && !r_tmo_clr;

  // Byte capture view for this cycle so a byte arriving with txn_done is counted first
  always_comb begin
    w_byte_cnt_next = r_byte_cnt;
    w_lo_next       = r_lo;
    w_hi_next       = r_hi;
    if (rd_valid) begin
      case (r_byte_cnt)
        2'd0:    w_lo_next = rd_data;
        2'd1:    w_hi_next = rd_data;
        default: ;
      endcase
      if (r_byte_cnt != 2'd3) w_byte_cnt_next = r_byte_cnt + 2'd1;
    end
  end

  // Byte assembly and shadow slots; contents only matter once a full frame lands
  always_ff @(posedge clk) begin
    if (r_state == ST_COLLECT) begin
      r_lo <= w_lo_next;
      r_hi <= w_hi_next;
      if (txn_done && r_idx != 2'd3) r_shadow[r_idx] <= {w_hi_next, w_lo_next};
    end
  end

  // Dropped-trigger counter, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_overrun <= 8'h00;
    else if (w_trig && r_state != ST_IDLE && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'h01;
  end

  // Frame sequencing FSM with registered command and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= 2'd0;
      r_byte_cnt    <= 2'd0;
      r_cmd_valid   <= 1'b0;
      r_cmd_reg     <= 8'h00;
      r_cmd_len     <= 2'd0;
      r_clear       <= 16'h0000;
      r_red         <= 16'h0000;
      r_green       <= 16'h0000;
      r_blue        <= 16'h0000;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_tmo_clr     <= 1'b0;
`ifdef COLOR_SEQ_INIT_EN
      r_cmd_rw      <= 1'b0;
      r_cmd_wdata   <= 8'h00;
      r_init_done   <= 1'b0;
      r_init_failed <= 1'b0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_tmo_clr     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef COLOR_SEQ_INIT_EN
          // Init runs on its own after reset; after a failed init it waits for a trigger
          if (!r_init_done && (!r_init_failed || w_trig)) begin
            r_state     <= ST_INIT_EN_WR;
            r_cmd_valid <= 1'b1;
            r_cmd_rw    <= 1'b0;
            r_cmd_reg   <= REG_ENABLE;
            r_cmd_wdata <= ENABLE_PON_AEN;
            r_cmd_len   <= 2'd1;
            r_busy      <= 1'b1;
            r_tmo_clr   <= 1'b1;
          end else if (w_trig) begin
`else
          if (w_trig) begin
`endif
            r_state     <= ST_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_reg   <= chan_reg(2'd0);
            r_cmd_len   <= 2'd2;
            r_busy      <= 1'b1;
            r_tmo_clr   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_timeout) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_FAIL;
          end else if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_state     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_byte_cnt <= w_byte_cnt_next;
          if (txn_done) begin
            if (txn_nack || w_byte_cnt_next != 2'd2) begin
              r_state <= ST_FAIL;
            end else if (r_idx != 2'd3) begin
              r_state <= ST_NEXT;
            end else begin
              // Last channel: all four words become visible together during PUBLISH
              r_clear       <= r_shadow[0];
              r_red         <= r_shadow[1];
              r_green       <= r_shadow[2];
              r_blue        <= {w_hi_next, w_lo_next};
              r_frame_valid <= 1'b1;
              r_state       <= ST_PUBLISH;
            end
          end else if (w_timeout) begin
            r_state <= ST_FAIL;
          end
        end
        ST_NEXT: begin
          r_idx       <= r_idx + 2'd1;
          r_cmd_valid <= 1'b1;
          r_cmd_reg   <= chan_reg(r_idx + 2'd1);
          r_cmd_len   <= 2'd2;
          r_tmo_clr   <= 1'b1;
          r_state     <= ST_ISSUE;
        end
        ST_PUBLISH: begin
          r_idx   <= 2'd0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          r_err       <= 1'b1;
          r_idx       <= 2'd0;
          r_busy      <= 1'b0;
          r_cmd_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
`ifdef COLOR_SEQ_INIT_EN
        ST_INIT_EN_WR, ST_INIT_AT_WR: begin
          if (w_timeout) begin
            r_cmd_valid   <= 1'b0;
            r_init_failed <= 1'b1;
            r_state       <= ST_FAIL;
          end else if (r_cmd_valid) begin
            if (cmd_ready) r_cmd_valid <= 1'b0;
          end else if (txn_done) begin
            if (txn_nack) begin
              r_init_failed <= 1'b1;
              r_state       <= ST_FAIL;
            end else if (r_state == ST_INIT_EN_WR) begin
              r_cmd_valid <= 1'b1;
              r_cmd_reg   <= REG_ATIME;
              r_cmd_wdata <= ATIME_VALUE;
              r_tmo_clr   <= 1'b1;
              r_state     <= ST_INIT_AT_WR;
            end else begin
              r_init_done   <= 1'b1;
              r_init_failed <= 1'b0;
              r_cmd_rw      <= 1'b1;
              r_cmd_wdata   <= 8'h00;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_reg     = r_cmd_reg;
  assign cmd_len     = r_cmd_len;
`ifdef COLOR_SEQ_INIT_EN
  assign cmd_rw      = r_cmd_rw;
  assign cmd_wdata   = r_cmd_wdata;
`else
  assign cmd_rw      = 1'b1;
  assign cmd_wdata   = 8'h00;
`endif
  assign clear_val   = r_clear;
  assign red_val     = r_red;
  assign green_val   = r_green;
  assign blue_val    = r_blue;
  assign frame_valid = r_frame_valid;
  assign busy        = r_busy;
  assign err         = r_err;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_color_frame_sequencer.sv
// Directed bench for color_frame_sequencer (default build, init writes disabled).
module tb_color_frame_sequencer;

  localparam int PERIOD = 1000;
  localparam int TMO    = 200;

  logic        clk = 1'b0;
  logic        reset, run, start, cmd_ready, rd_valid, txn_done, txn_nack;
  logic [7:0]  rd_data;
  logic        cmd_valid, cmd_rw, frame_valid, busy, err;
  logic [7:0]  cmd_reg, cmd_wdata, overrun_cnt;
  logic [1:0]  cmd_len;
  logic [15:0] clear_val, red_val, green_val, blue_val;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cmd_cyc = 0;
  int t0 = 0;
  int w = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  color_frame_sequencer #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .txn_done(txn_done), .txn_nack(txn_nack),
    .clear_val(clear_val), .red_val(red_val), .green_val(green_val), .blue_val(blue_val),
    .frame_valid(frame_valid), .busy(busy), .err(err), .overrun_cnt(overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sensor-side responder for one read transaction
  task automatic serve(input string tag, input logic [7:0] exp_reg, input logic [7:0] lo,
                       input logic [7:0] hi, input logic nack, input int nbytes,
                       input logic merge, input int max_wait);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_valid && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd1);
    if (cmd_valid) begin
      last_cmd_cyc = cyc;
      check({tag, "_cmd_reg"}, 32'(cmd_reg), 32'(exp_reg));
      check({tag, "_cmd_len"}, 32'(cmd_len), 32'd2);
      check({tag, "_cmd_rw"}, 32'(cmd_rw), 32'd1);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(cmd_valid), 32'd0);
      for (int i = 0; i < nbytes; i++) begin
        rd_valid = 1'b1;
        rd_data  = (i == 0) ? lo : (i == 1) ? hi : 8'hEE;
        if (merge && i == nbytes - 1) begin
          txn_done = 1'b1;
          txn_nack = nack;
        end
        @(negedge clk);
      end
      rd_valid = 1'b0;
      if (!(merge && nbytes > 0)) begin
        txn_done = 1'b1;
        txn_nack = nack;
        @(negedge clk);
      end
      txn_done = 1'b0;
      txn_nack = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; start = 1'b0; cmd_ready = 1'b0;
    rd_valid = 1'b0; rd_data = 8'h00; txn_done = 1'b0; txn_nack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_reg", 32'(cmd_reg), 32'd0);
    check("rst_cmd_len", 32'(cmd_len), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_clear", 32'(clear_val), 32'd0);
    check("rst_blue", 32'(blue_val), 32'd0);
    check("rst_wdata", 32'(cmd_wdata), 32'd0);

    // Periodic frame with the reference byte pattern
    reset = 1'b1;
    run   = 1'b1;
    serve("A_clr", 8'h14, 8'h34, 8'h12, 1'b0, 2, 1'b0, PERIOD + 100);
    t0 = last_cmd_cyc;
    check("A_busy", 32'(busy), 32'd1);
    check("A_no_early_pub", 32'(clear_val), 32'd0);
    serve("A_red", 8'h16, 8'h78, 8'h56, 1'b0, 2, 1'b0, 20);
    serve("A_grn", 8'h18, 8'hBC, 8'h9A, 1'b0, 2, 1'b0, 20);
    check("A_partial_hidden", 32'(red_val), 32'd0);
    serve("A_blu", 8'h1A, 8'hF0, 8'hDE, 1'b0, 2, 1'b0, 20);
    check("A_frame_valid", 32'(frame_valid), 32'd1);
    check("A_clear", 32'(clear_val), 32'h1234);
    check("A_red", 32'(red_val), 32'h5678);
    check("A_green", 32'(green_val), 32'h9ABC);
    check("A_blue", 32'(blue_val), 32'hDEF0);
    check("A_err", 32'(err), 32'd0);
    @(negedge clk);
    check("A_fv_one_cycle", 32'(frame_valid), 32'd0);
    check("A_busy_idle", 32'(busy), 32'd0);

    // Start a frame shortly before the next tick; a start and the tick both land while busy
    while (cyc < t0 + PERIOD - 15) @(negedge clk);
    pulse_start();
    serve("B_clr", 8'h14, 8'h11, 8'h22, 1'b0, 2, 1'b0, 20);
    pulse_start();
    check("B_overrun1", 32'(overrun_cnt), 32'd1);
    serve("B_red", 8'h16, 8'h33, 8'h44, 1'b0, 2, 1'b0, 20);
    serve("B_grn", 8'h18, 8'h55, 8'h66, 1'b0, 2, 1'b0, 20);
    serve("B_blu", 8'h1A, 8'h77, 8'h88, 1'b0, 2, 1'b0, 20);
    check("B_frame_valid", 32'(frame_valid), 32'd1);
    check("B_overrun2", 32'(overrun_cnt), 32'd2);
    check("B_clear", 32'(clear_val), 32'h2211);
    check("B_blue", 32'(blue_val), 32'h8877);

    // GREEN read NACKed: error, no publish, previous frame retained
    serve("C_clr", 8'h14, 8'hAA, 8'hBB, 1'b0, 2, 1'b0, PERIOD + 100);
    serve("C_red", 8'h16, 8'hCC, 8'hDD, 1'b0, 2, 1'b0, 20);
    serve("C_grn", 8'h18, 8'hEE, 8'hFF, 1'b1, 2, 1'b0, 20);
    check("C_no_frame", 32'(frame_valid), 32'd0);
    @(negedge clk);
    check("C_err", 32'(err), 32'd1);
    check("C_busy", 32'(busy), 32'd0);
    check("C_no_retry_cmd", 32'(cmd_valid), 32'd0);
    check("C_keep_clear", 32'(clear_val), 32'h2211);
    check("C_keep_red", 32'(red_val), 32'h4433);
    check("C_keep_blue", 32'(blue_val), 32'h8877);
    // Next period retries from CLEAR; last byte arrives with txn_done
    serve("D_clr", 8'h14, 8'h01, 8'hA0, 1'b0, 2, 1'b0, PERIOD + 100);
    serve("D_red", 8'h16, 8'h02, 8'hB0, 1'b0, 2, 1'b0, 20);
    serve("D_grn", 8'h18, 8'h03, 8'hC0, 1'b0, 2, 1'b0, 20);
    serve("D_blu", 8'h1A, 8'h04, 8'hD0, 1'b0, 2, 1'b1, 20);
    check("D_frame_valid", 32'(frame_valid), 32'd1);
    check("D_clear", 32'(clear_val), 32'hA001);
    check("D_red", 32'(red_val), 32'hB002);
    check("D_green", 32'(green_val), 32'hC003);
    check("D_blue", 32'(blue_val), 32'hD004);
    check("D_err_sticky", 32'(err), 32'd1);
    check("D_overrun", 32'(overrun_cnt), 32'd2);

    // Hold start high for 300 cycles with the master stalled: counter saturates
    run = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (300) @(negedge clk);
    start = 1'b0;
    w = 0;
    while (busy && w < 3 * TMO) begin
      @(negedge clk);
      w++;
    end
    check("S_idle", 32'(busy), 32'd0);
    check("S_overrun_sat", 32'(overrun_cnt), 32'd255);

    // Reset asserted mid-COLLECT of RED
    pulse_start();
    serve("E_clr", 8'h14, 8'h55, 8'h66, 1'b0, 2, 1'b0, 20);
    @(negedge clk);
    check("E_red_valid", 32'(cmd_valid), 32'd1);
    check("E_red_reg", 32'(cmd_reg), 32'h16);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    rd_valid = 1'b1;
    rd_data  = 8'h77;
    @(negedge clk);
    rd_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("E_busy", 32'(busy), 32'd0);
    check("E_cmd_valid", 32'(cmd_valid), 32'd0);
    check("E_err", 32'(err), 32'd0);
    check("E_overrun", 32'(overrun_cnt), 32'd0);
    check("E_clear", 32'(clear_val), 32'd0);
    check("E_green", 32'(green_val), 32'd0);
    check("E_blue", 32'(blue_val), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Clean frame after reset release
    pulse_start();
    serve("F_clr", 8'h14, 8'h10, 8'h01, 1'b0, 2, 1'b0, 20);
    serve("F_red", 8'h16, 8'h20, 8'h02, 1'b0, 2, 1'b1, 20);
    serve("F_grn", 8'h18, 8'h30, 8'h03, 1'b0, 2, 1'b0, 20);
    serve("F_blu", 8'h1A, 8'h40, 8'h04, 1'b0, 2, 1'b0, 20);
    check("F_frame_valid", 32'(frame_valid), 32'd1);
    check("F_clear", 32'(clear_val), 32'h0110);
    check("F_red", 32'(red_val), 32'h0220);
    check("F_green", 32'(green_val), 32'h0330);
    check("F_blue", 32'(blue_val), 32'h0440);
    check("F_err", 32'(err), 32'd0);
    @(negedge clk);

    // cmd_ready held low: transaction times out
    pulse_start();
    check("G_valid", 32'(cmd_valid), 32'd1);
    check("G_reg", 32'(cmd_reg), 32'h14);
    repeat (TMO - 20) @(negedge clk);
    check("G_still_valid", 32'(cmd_valid), 32'd1);
    check("G_no_err_yet", 32'(err), 32'd0);
    w = 0;
    while (cmd_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("G_valid_dropped", 32'(cmd_valid), 32'd0);
    check("G_not_early", 32'(w >= 15), 32'd1);
    @(negedge clk);
    check("G_err", 32'(err), 32'd1);
    check("G_busy", 32'(busy), 32'd0);
    check("G_keep_clear", 32'(clear_val), 32'h0110);

    // Three bytes in one read is a length error; retry starts at CLEAR
    pulse_start();
    serve("H_clr", 8'h14, 8'h99, 8'h88, 1'b0, 3, 1'b0, 20);
    check("H_no_frame", 32'(frame_valid), 32'd0);
    @(negedge clk);
    check("H_busy", 32'(busy), 32'd0);
    pulse_start();
    serve("H2_clr", 8'h14, 8'h57, 8'h13, 1'b0, 2, 1'b0, 20);
    serve("H2_red", 8'h16, 8'h68, 8'h24, 1'b0, 2, 1'b0, 20);
    serve("H2_grn", 8'h18, 8'h79, 8'h35, 1'b0, 2, 1'b0, 20);
    serve("H2_blu", 8'h1A, 8'h8A, 8'h46, 1'b0, 2, 1'b0, 20);
    check("H2_frame_valid", 32'(frame_valid), 32'd1);
    check("H2_clear", 32'(clear_val), 32'h1357);
    check("H2_blue", 32'(blue_val), 32'h468A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
